onehot_encoder_stream: RTL and testbench
========================================

// Module: onehot_encoder_stream
// PURPOSE
//  Streaming inverse of the 1-to-N decoder: converts one-hot N-bit words to binary indices.
//  Valid/ready on both sides, with a 2-entry skid buffer, so back-pressure never drops or reorders words.
//  Non-one-hot words are flagged on output and counted.
//  Sits between decoder-style select buses and index-consuming logic.
// PARAMETERS
//  N    4             one-hot input width; N>=2
//  W    $clog2(N)     output index width; derived, not overridden
//  CW   8             width of the saturating error counter
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_data is valid this cycle
//  in_ready   out  1    block can accept a word this cycle
//  in_data    in   N    one-hot input word
//  out_valid  out  1    out_idx/out_err are valid this cycle
//  out_ready  in   1    downstream accepts the output this cycle
//  out_idx    out  W    binary index of the lowest set bit of the head word
//  out_err    out  1    head word was not exactly one-hot (zero bits or more than one bit set)
//  err_cnt    out  CW   count of accepted non-one-hot words; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - out_valid=0, out_idx=0, out_err=0, err_cnt=0, in_ready=1, state=EMPTY.
//   - Buffered words are discarded. Reset has priority over every handshake in the same cycle.
//  Transfers:
//   - Input accept: in_valid & in_ready. Output pop: out_valid & out_ready.
//   - Output fields stay stable while out_valid=1 and out_ready=0.
//   - Output is registered. Latency is 1 cycle from accept to out_valid when the buffer is empty.
//  Encoding per word:
//   - exactly one bit k set -> idx=k, err=0.
//   - zero bits set -> idx=0, err=1.
//   - several bits set -> idx=lowest set bit, err=1.
//  FSM (buffer occupancy):
//   - EMPTY: accept -> ONE.
//   - ONE: accept & ~pop -> FULL; pop & ~accept -> EMPTY; accept & pop -> ONE (head replaced).
//   - FULL: in_ready=0, so no accept; pop -> ONE (skid entry moves to head).
//  in_ready:
//   - Registered output; in_ready = (next_state != FULL).
//   - It never depends combinationally on out_ready.
//  Word order is strictly FIFO. No word is lost or duplicated under any valid/ready pattern.
//  err_cnt:
//   - Increments by 1 on each accepted word with err=1, at accept time, not pop time.
//   - Holds at 2^CW-1 when saturated.
//  in_valid asserted while in_ready=0: word is ignored. Upstream must hold it; no error is raised.
// STRUCTURE
//  Shared package: state encodings EMPTY/ONE/FULL and the default CW.
//  Sub-module onehot_enc_comb (N, W):
//   - Purely combinational: in_data -> {idx, err}.
//   - Instantiated once, on the input side.
//   - The buffer stores encoded {idx, err}, not raw N-bit words.
//  Top level contains the FSM, 2 entries of W+1 bits, and the err counter.
// TESTING (N=4, CW=8)
//  1. out_ready=1; send 0001, 0010, 0100, 1000 back-to-back.
//     -> out_idx 0,1,2,3 on consecutive cycles, err=0, 1-cycle latency.
//  2. Send 0000, then 0110.
//     -> (idx0, err1), then (idx1, err1); err_cnt ends at 2.
//  3. out_ready=0; offer 1000, 0100, 0010 continuously.
//     -> first two accepted, in_ready=0 after the second, third held.
//     -> Release out_ready: outputs 3,2,1 in order with no loss.
//  4. Simultaneous accept and pop in ONE for 10 cycles.
//     -> state stays ONE, in_ready=1 throughout, throughput 1 word/cycle.
//  5. Send 260 words of 1111.
//     -> err_cnt reaches 255 and holds; out_idx=0, err=1 on every word.
//  6. Assert rst while FULL with out_ready=0.
//     -> next cycle: out_valid=0, in_ready=1, err_cnt=0.
//     -> Next word 0010 emerges as idx1 with no stale data.

Source files
------------

// File: rtl/onehot_encoder_stream_pkg.sv
// Shared constants for the one-hot encoder stream.
// Buffer-occupancy state encodings and default counter width.
package onehot_encoder_stream_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int CW_DEFAULT = 8;

endpackage

// File: rtl/onehot_encoder_stream_enc_comb.sv
// Combinational one-hot to binary encoder.
// Reports the lowest set bit and flags words that are not exactly one-hot.
module onehot_enc_comb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] in_data,
    output logic [W-1:0] idx,
    output logic         err
);

    // Scan downward so the lowest set bit is the one that sticks.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_data[i]) begin
                idx = W'(i);
            end
        end
        err = (in_data == '0) ||
              ((in_data & (in_data - N'(1))) != '0);
    end

endmodule

// File: rtl/onehot_encoder_stream.sv
// Streaming one-hot to index converter.
// Two-entry skid buffer of encoded words plus a saturating error counter.
module onehot_encoder_stream
    import onehot_encoder_stream_pkg::*;
#(
    parameter int  N  = 4,
    localparam int W  = $clog2(N),
    parameter int  CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_idx,
    output logic          out_err,
    output logic [CW-1:0] err_cnt
);

    logic [W-1:0] enc_idx;
    logic         enc_err;
    logic [W-1:0] skid_idx;
    logic         skid_err;
    logic [1:0]   state;
    logic [1:0]   next_state;
    logic         accept;
    logic         pop;

    onehot_enc_comb #(
        .N (N),
        .W (W)
    ) u_enc (
        .in_data (in_data),
        .idx     (enc_idx),
        .err     (enc_err)
    );

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Occupancy transitions; FULL never sees an accept since in_ready is low.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_EMPTY: if (accept) next_state = ST_ONE;
            ST_ONE: begin
                if (accept && !pop) begin
                    next_state = ST_FULL;
                end else if (pop && !accept) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL:  if (pop) next_state = ST_ONE;
            default:  next_state = ST_EMPTY;
        endcase
    end

    // State plus registered handshake outputs derived from next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != ST_EMPTY);
            in_ready  <= (next_state != ST_FULL);
        end
    end

    // Head and skid entries; head only changes when empty or popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx  <= '0;
            out_err  <= 1'b0;
            skid_idx <= '0;
            skid_err <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_idx <= enc_idx;
                        out_err <= enc_err;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        out_idx <= enc_idx;
                        out_err <= enc_err;
                    end else if (accept) begin
                        skid_idx <= enc_idx;
                        skid_err <= enc_err;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        out_idx <= skid_idx;
                        out_err <= skid_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count malformed words when they enter, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && enc_err && (err_cnt != {CW{1'b1}})) begin
            err_cnt <= err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Scoreboard bench for onehot_encoder_stream.
// Driver pushes expected {idx,err} on accept; monitor pops on each output transfer.
module tb_onehot_encoder_stream;
    import onehot_encoder_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_idx;
    logic       out_err;
    logic [7:0] err_cnt;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
    } exp_t;

    exp_t q[$];

    onehot_encoder_stream #(.N(4), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output transfer occurs at the next rising edge; compare at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_output: got idx %0d with empty queue", out_idx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_idx", int'(out_idx), int'(e.idx));
                chk("out_err", int'(out_err), int'(e.err));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [1:0] ei, input logic ee);
        int n;
        bit done;
        exp_t e;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                e.idx = ei;
                e.err = ee;
                q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", int'(q.size() == 0 && !out_valid), 1);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        tick(2);
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_err", int'(out_err), 0);

        // 1: back-to-back valid words
        out_ready = 1'b1;
        send(4'b0001, 2'd0, 1'b0);
        chk("t1_latency_valid", int'(out_valid), 1);
        chk("t1_latency_idx", int'(out_idx), 0);
        send(4'b0010, 2'd1, 1'b0);
        send(4'b0100, 2'd2, 1'b0);
        send(4'b1000, 2'd3, 1'b0);
        drain();
        chk("t1_err_cnt", int'(err_cnt), 0);

        // 2: malformed words
        send(4'b0000, 2'd0, 1'b1);
        send(4'b0110, 2'd1, 1'b1);
        drain();
        chk("t2_err_cnt", int'(err_cnt), 2);

        // 3: back-pressure with skid
        out_ready = 1'b0;
        send(4'b1000, 2'd3, 1'b0);
        chk("t3_ready_after1", int'(in_ready), 1);
        send(4'b0100, 2'd2, 1'b0);
        chk("t3_ready_after2", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 4'b0010;
        tick(3);
        chk("t3_held_ready", int'(in_ready), 0);
        chk("t3_held_idx", int'(out_idx), 3);
        chk("t3_held_valid", int'(out_valid), 1);
        chk("t3_queue", q.size(), 2);
        out_ready = 1'b1;
        send(4'b0010, 2'd1, 1'b0);
        drain();
        chk("t3_err_cnt", int'(err_cnt), 2);

        // 4: steady state accept+pop in ONE
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] d;
            d = 4'b0001 << (i % 4);
            send(d, 2'(i % 4), 1'b0);
            chk("t4_state", int'(dut.state), int'(ST_ONE));
            chk("t4_in_ready", int'(in_ready), 1);
        end
        chk("t4_cycles", cyc - c0, 10);
        drain();

        // 5: counter saturation
        for (int i = 0; i < 260; i++) begin
            send(4'b1111, 2'd0, 1'b1);
            if (i == 252) chk("t5_cnt_253", int'(err_cnt), 255);
        end
        drain();
        chk("t5_err_cnt_sat", int'(err_cnt), 255);

        // 6: reset while full
        out_ready = 1'b0;
        send(4'b0100, 2'd2, 1'b0);
        send(4'b1000, 2'd3, 1'b0);
        chk("t6_full", int'(in_ready), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_err_cnt", int'(err_cnt), 0);
        out_ready = 1'b1;
        send(4'b0010, 2'd1, 1'b0);
        chk("t6_idx", int'(out_idx), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
